poly_split_param: RTL and testbench

Parameterised, coefficient-serial polynomial splitter for the Niederreiter ALU. It is the next generation of the fixed 144-bit SPLIT unit.
- Takes a polynomial of T coefficients over GF(2^M), packed in one vector.
- Produces two fragment vectors, either even/odd-indexed coefficients (mode 0, used by the square-root step in Patterson decoding) or low/high halves (mode 1).
- Uses a start/busy/done handshake. LANES sets the throughput/area trade-off.

---
 rtl/poly_split_param.sv | 106 ++++++++++
 tb/tb_poly_split_param.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/poly_split_param.sv
// rtl/poly_split_param.sv - coefficient-serial even/odd or half splitter for GF(2^M) polynomials
module poly_split_param #(
  parameter int M     = 12,
  parameter int T     = 12,
  parameter int LANES = 1
) (
  input  logic           clk,
  input  logic           rst_b,
  input  logic           start,
  input  logic           mode,
  input  logic [0:M*T-1] poly_in,
  output logic           busy,
  output logic           done,
  output logic [0:M*T-1] first_fragment_out,
  output logic [0:M*T-1] second_fragment_out
);

  localparam int DAT_W = M * T;
  localparam int H     = (T + 1) / 2;
  localparam int IW    = $clog2(T + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q;
  logic [0:DAT_W-1] shadow_q;
  logic             mode_q;
  logic [IW-1:0]    idx_q;
  logic [0:DAT_W-1] acc1_q, acc1_d;
  logic [0:DAT_W-1] acc2_q, acc2_d;
  logic             busy_q, done_q;
  logic [0:DAT_W-1] first_q, second_q;

  // Every slot is written exactly once per operation, so zero padding comes
  // from clearing the accumulators at start.
  always_comb begin
    acc1_d = acc1_q;
    acc2_d = acc2_q;
    for (int l = 0; l < LANES; l++) begin : g_lane
      int         c;
      logic [M-1:0] coef;
      c    = int'(idx_q) + l;
      coef = shadow_q[c*M +: M];
      if (!mode_q) begin
        if ((c % 2) == 0) acc1_d[(c/2)*M +: M] = coef;
        else              acc2_d[(c/2)*M +: M] = coef;
      end else begin
        if (c < H) acc1_d[c*M +: M]     = coef;
        else       acc2_d[(c-H)*M +: M] = coef;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      mode_q   <= 1'b0;
      idx_q    <= '0;
      acc1_q   <= '0;
      acc2_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      first_q  <= '0;
      second_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            shadow_q <= poly_in;
            mode_q   <= mode;
            idx_q    <= '0;
            acc1_q   <= '0;
            acc2_q   <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          acc1_q <= acc1_d;
          acc2_q <= acc2_d;
          idx_q  <= idx_q + IW'(LANES);
          // Final lanes go straight to the outputs so done lines up with DONE.
          if (idx_q == IW'(T - LANES)) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            first_q  <= acc1_d;
            second_q <= acc2_d;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign first_fragment_out  = first_q;
  assign second_fragment_out = second_q;

endmodule

// File: tb/tb_poly_split_param.sv
// tb/tb_poly_split_param.sv - directed vector bench for poly_split_param
module tb_poly_split_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_b;

  logic         start_a, mode_a, busy_a, done_a;
  logic [0:143] poly_a, f_a, s_a;
  logic         start_b, mode_b, busy_b, done_b;
  logic [0:143] poly_b, f_b, s_b;
  logic         start_c, mode_c, busy_c, done_c;
  logic [0:39]  poly_c, f_c, s_c;

  poly_split_param #(.M(12), .T(12), .LANES(1)) u_a (
    .clk(clk), .rst_b(rst_b), .start(start_a), .mode(mode_a), .poly_in(poly_a),
    .busy(busy_a), .done(done_a), .first_fragment_out(f_a), .second_fragment_out(s_a));

  poly_split_param #(.M(12), .T(12), .LANES(4)) u_b (
    .clk(clk), .rst_b(rst_b), .start(start_b), .mode(mode_b), .poly_in(poly_b),
    .busy(busy_b), .done(done_b), .first_fragment_out(f_b), .second_fragment_out(s_b));

  poly_split_param #(.M(8), .T(5), .LANES(1)) u_c (
    .clk(clk), .rst_b(rst_b), .start(start_c), .mode(mode_c), .poly_in(poly_c),
    .busy(busy_c), .done(done_c), .first_fragment_out(f_c), .second_fragment_out(s_c));

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int           sel;
    logic         m;
    logic [0:143] p;
    logic [0:143] f;
    logic [0:143] s;
    int           lat;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input logic [0:143] act, input logic [0:143] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic drive(input int sel, input logic st, input logic m, input logic [0:143] p);
    case (sel)
      0: begin start_a = st; mode_a = m; poly_a = p; end
      1: begin start_b = st; mode_b = m; poly_b = p; end
      default: begin start_c = st; mode_c = m; poly_c = p[0:39]; end
    endcase
  endtask

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
  endfunction

  function automatic logic get_done(input int sel);
    return (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
  endfunction

  function automatic logic [0:143] get_f(input int sel);
    return (sel == 0) ? f_a : (sel == 1) ? f_b : {f_c, 104'h0};
  endfunction

  function automatic logic [0:143] get_s(input int sel);
    return (sel == 0) ? s_a : (sel == 1) ? s_b : {s_c, 104'h0};
  endfunction

  // Cycle k is the period that ends at clock edge k; start is sampled at edge 0.
  task automatic run_op(input string nm, input int sel, input logic m, input logic [0:143] p,
                        input logic [0:143] ef, input logic [0:143] es, input int exp_lat,
                        input bit restart);
    logic [0:143] gf, gs;
    int lat, nd, berr;
    gf = '0; gs = '0; lat = -1; nd = 0; berr = 0;
    @(negedge clk);
    drive(sel, 1'b1, m, p);
    @(posedge clk);
    #1 drive(sel, 1'b0, m, p);
    for (int k = 1; k <= exp_lat + 10; k++) begin
      @(negedge clk);
      if (get_done(sel)) begin
        nd++;
        if (lat < 0) begin
          lat = k; gf = get_f(sel); gs = get_s(sel);
        end
      end
      if (get_busy(sel) !== (k < exp_lat)) berr++;
      if (restart && (k == 3 || k == 12)) begin
        drive(sel, 1'b1, ~m, ~p);
        @(posedge clk);
        #1 drive(sel, 1'b0, m, p);
      end
    end
    chk_i({nm, " latency"}, lat, exp_lat);
    chk_i({nm, " done_count"}, nd, 1);
    chk_i({nm, " busy_profile_errs"}, berr, 0);
    chk({nm, " first"}, gf, ef);
    chk({nm, " second"}, gs, es);
    chk({nm, " first_hold"}, get_f(sel), ef);
  endtask

  logic [0:143] inc, pat, ones;
  int nd, nb;

  initial begin
    inc  = 144'h00100200300400500600700800900A00B00C;
    pat  = 144'hABCDEF1234567890F0F0F555AAA3C3C3C999;
    ones = '1;

    vt[0] = '{0, 1'b0, inc, {72'h00100300500700900B, 72'h0}, {72'h00200400600800A00C, 72'h0}, 13};
    vt[1] = '{0, 1'b1, inc, {72'h001002003004005006, 72'h0}, {72'h00700800900A00B00C, 72'h0}, 13};
    vt[2] = '{0, 1'b0, pat, {72'hABC123789F0FAAAC3C, 72'h0}, {72'hDEF4560F05553C3999, 72'h0}, 13};
    vt[3] = '{0, 1'b1, pat, {72'hABCDEF1234567890F0, 72'h0}, {72'hF0F555AAA3C3C3C999, 72'h0}, 13};
    vt[4] = '{1, 1'b1, inc, {72'h001002003004005006, 72'h0}, {72'h00700800900A00B00C, 72'h0}, 4};
    vt[5] = '{1, 1'b0, pat, {72'hABC123789F0FAAAC3C, 72'h0}, {72'hDEF4560F05553C3999, 72'h0}, 4};
    vt[6] = '{2, 1'b0, {40'h1122334455, 104'h0}, {40'h1133550000, 104'h0}, {40'h2244000000, 104'h0}, 6};
    vt[7] = '{2, 1'b1, {40'h1122334455, 104'h0}, {40'h1122330000, 104'h0}, {40'h4455000000, 104'h0}, 6};

    rst_b = 1'b0;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 1'b0, '0);
    repeat (2) @(negedge clk);
    chk_i("reset busy_a", int'(busy_a), 0);
    chk_i("reset done_a", int'(done_a), 0);
    chk("reset first_a", f_a, '0);
    chk("reset second_a", s_a, '0);
    chk("reset first_c", {f_c, 104'h0}, '0);
    rst_b = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vt[i].sel, vt[i].m, vt[i].p, vt[i].f, vt[i].s, vt[i].lat, 1'b0);

    run_op("start_ignored", 0, 1'b1, pat, {72'hABCDEF1234567890F0, 72'h0},
           {72'hF0F555AAA3C3C3C999, 72'h0}, 13, 1'b1);

    // Abandon an operation mid-run; the previous result must be wiped.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, inc);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, inc);
    repeat (6) @(negedge clk);
    rst_b = 1'b0;
    #1;
    chk_i("midreset busy", int'(busy_a), 0);
    chk_i("midreset done", int'(done_a), 0);
    chk("midreset first", f_a, '0);
    chk("midreset second", s_a, '0);
    @(negedge clk);
    rst_b = 1'b1;
    nd = 0; nb = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_a) nd++;
      if (busy_a) nb++;
    end
    chk_i("midreset no_done", nd, 0);
    chk_i("midreset no_busy", nb, 0);

    run_op("after_reset_fff", 0, 1'b0, ones, {72'hFFFFFFFFFFFFFFFFFF, 72'h0},
           {72'hFFFFFFFFFFFFFFFFFF, 72'h0}, 13, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
